// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl
//   Walks a masked set of demux channels in ascending order. Each visited
//   channel gets din held high for dwell+1 cycles with sel parked on it,
//   followed by one quiet GAP cycle before the scan moves on. A one-cycle
//   done pulse closes every accepted scan.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   scan request, sampled only while idle
//   mask   in   [N-1:0] channels to visit (latched at start)
//   dwell  in   [DW-1:0] drive length per channel minus one (latched at start)
//   sel    out  [SIZE-1:0] demux channel select
//   din    out  demux data bit
//   busy   out  scan in progress
//   done   out  one-cycle scan-complete pulse
//
// Every output is a flop loaded from the next-state decode, so the
// outputs always describe the current state with no input-to-output path.
module demux_scan_ctrl #(
    parameter int SIZE = 3,
    parameter int DW   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<SIZE)-1:0]   mask,
    input  logic [DW-1:0]          dwell,
    output logic [SIZE-1:0]        sel,
    output logic                   din,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {IDLE, SEEK, DRIVE, GAP, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SIZE-1:0]        idx, idx_nxt;
    logic [DW-1:0]          cnt, cnt_nxt;
    logic [(1<<SIZE)-1:0]   mask_q, mask_nxt;
    logic [DW-1:0]          dwell_q, dwell_nxt;
    logic [SIZE-1:0]        sel_nxt;
    logic                   din_nxt, busy_nxt, done_nxt;
    logic                   last_ch;

    assign last_ch = &idx;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            mask_q  <= mask_nxt;
            dwell_q <= dwell_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        mask_nxt  = mask_q;
        dwell_nxt = dwell_q;
        case (state)
            IDLE: begin
                if (start) begin
                    // idx restarts on any accepted start so an empty scan
                    // reports sel=0 rather than the previous scan's last index
                    idx_nxt = '0;
                    if (mask != '0) begin
                        mask_nxt  = mask;
                        dwell_nxt = dwell;
                        state_nxt = SEEK;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            SEEK: begin
                if (mask_q[idx]) begin
                    cnt_nxt   = dwell_q;
                    state_nxt = DRIVE;
                end else if (last_ch) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + SIZE'(1);
                end
            end
            DRIVE: begin
                if (cnt != '0) cnt_nxt = cnt - DW'(1);
                else           state_nxt = GAP;
            end
            GAP: begin
                if (last_ch) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + SIZE'(1);
                    state_nxt = SEEK;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the state being entered
    always_comb begin
        sel_nxt  = idx_nxt;
        din_nxt  = (state_nxt == DRIVE);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel  <= '0;
            din  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            sel  <= sel_nxt;
            din  <= din_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Self-checking bench for demux_scan_ctrl. A trace model builds the cycle
// by cycle output sequence of a scan straight from the channel/dwell rules;
// the DUT outputs are sampled on the falling edge and compared against it.
module tb_demux_scan_ctrl;

    localparam int SIZE = 3;
    localparam int DW   = 4;
    localparam int N    = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    mask;
    logic [DW-1:0]   dwell;
    logic [SIZE-1:0] sel;
    logic            din, busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [SIZE-1:0] sel;
        logic            din;
        logic            busy;
        logic            done;
    } obs_t;

    obs_t            exp_q[$];
    obs_t            obs_q[$];
    logic [SIZE-1:0] last_sel = '0;

    demux_scan_ctrl #(.SIZE(SIZE), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .dwell(dwell),
        .sel(sel), .din(din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int s, input bit di, input bit bu, input bit dn);
        obs_t o;
        o.sel  = SIZE'(s);
        o.din  = di;
        o.busy = bu;
        o.done = dn;
        return o;
    endfunction

    // Expected outputs for one scan, beginning with the cycle after start
    // is accepted: every channel costs one seek cycle, a visited channel
    // then adds dwell+1 drive cycles and one gap cycle; a done cycle closes.
    task automatic build_scan(input logic [N-1:0] m, input logic [DW-1:0] d);
        if (m == '0) begin
            exp_q.push_back(mk(0, 0, 1, 1));
            last_sel = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back(mk(i, 0, 1, 0));
                if (m[i]) begin
                    for (int c = 0; c <= int'(d); c++) exp_q.push_back(mk(i, 1, 1, 0));
                    exp_q.push_back(mk(i, 0, 1, 0));
                end
            end
            exp_q.push_back(mk(N - 1, 0, 1, 1));
            last_sel = SIZE'(N - 1);
        end
    endtask

    // Records n falling-edge samples; in between it either holds start,
    // or (noise) hammers start/mask/dwell, or drops start. Start is always
    // low by the last sample.
    task automatic collect(input int n, input bit noise, input bit hold);
        obs_q.delete();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            obs_q.push_back(mk(int'(sel), din, busy, done));
            if (k == n - 1)  start = 1'b0;
            else if (hold)   start = 1'b1;
            else if (noise) begin
                start = 1'($urandom_range(0, 1));
                mask  = N'($urandom);
                dwell = DW'($urandom);
            end else         start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mask = '0; dwell = '0;
        #1;
        checks++;
        if ({sel, din, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got sel=%0d din=%b busy=%b done=%b want all zero",
                     sel, din, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One scan: start pulsed with (m,d), trace compared, then one idle cycle.
    task automatic test_scan(input string name, input logic [N-1:0] m,
                             input logic [DW-1:0] d, input bit noise, input int want_busy);
        int busy_cnt;
        exp_q.delete();
        build_scan(m, d);
        start = 1'b1; mask = m; dwell = d;
        collect(exp_q.size(), noise, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            busy_cnt += int'(obs_q[k].busy);
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL %s cyc%0d got sel=%0d din=%b busy=%b done=%b want sel=%0d din=%b busy=%b done=%b",
                         name, k, obs_q[k].sel, obs_q[k].din, obs_q[k].busy, obs_q[k].done,
                         exp_q[k].sel, exp_q[k].din, exp_q[k].busy, exp_q[k].done);
            end
        end
        if (want_busy > 0) begin
            checks++;
            if (busy_cnt != want_busy) begin
                failures++;
                $display("FAIL %s_length got %0d busy cycles want %0d", name, busy_cnt, want_busy);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sel, din, busy, done} !== {last_sel, 3'b000}) begin
            failures++;
            $display("FAIL %s_idle got sel=%0d din=%b busy=%b done=%b want sel=%0d din=0 busy=0 done=0",
                     name, sel, din, busy, done, last_sel);
        end
    endtask

    task automatic test_mid_reset();
        int stop;
        exp_q.delete();
        build_scan('1, 4'd5);
        stop = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (stop == 0 && exp_q[k].sel == 3 && exp_q[k].din) stop = k + 3;
        start = 1'b1; mask = '1; dwell = 4'd5;
        collect(stop, 1'b0, 1'b0);
        for (int k = 0; k < stop; k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL mid_reset_pre cyc%0d got sel=%0d din=%b want sel=%0d din=%b",
                         k, obs_q[k].sel, obs_q[k].din, exp_q[k].sel, exp_q[k].din);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sel, din, busy, done} !== '0) begin
            failures++;
            $display("FAIL mid_reset_abort got sel=%0d din=%b busy=%b done=%b want all zero",
                     sel, din, busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_hold got busy=%b done=%b want 0 0", busy, done);
            end
        end
        rst = 1'b0;
        test_scan("after_reset", N'(8'h12), 4'd2, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int dones;
        exp_q.delete();
        build_scan(N'(8'h81), 4'd1);
        exp_q.push_back(mk(int'(last_sel), 0, 0, 0));
        build_scan(N'(8'h81), 4'd1);
        start = 1'b1; mask = N'(8'h81); dwell = 4'd1;
        collect(exp_q.size(), 1'b0, 1'b1);
        dones = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            dones += int'(obs_q[k].done);
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL back_to_back cyc%0d got sel=%0d din=%b busy=%b done=%b want sel=%0d din=%b busy=%b done=%b",
                         k, obs_q[k].sel, obs_q[k].din, obs_q[k].busy, obs_q[k].done,
                         exp_q[k].sel, exp_q[k].din, exp_q[k].busy, exp_q[k].done);
            end
        end
        checks++;
        if (dones != 2) begin
            failures++;
            $display("FAIL back_to_back_dones got %0d want 2", dones);
        end
    endtask

    initial begin
        test_reset();
        test_scan("empty", '0, 4'd3, 1'b0, 1);
        test_scan("single", N'(8'h01), 4'd1, 1'b0, 1 + 2 + 1 + 7 + 1);
        test_scan("sparse", N'(8'hA0), 4'd0, 1'b0, 0);
        test_scan("full_max", '1, 4'hF, 1'b0, N * (1 + 16 + 1) + 1);
        test_scan("ignore_mid", N'(8'h5C), 4'd2, 1'b1, 0);
        for (int r = 0; r < 6; r++)
            test_scan("random", N'($urandom), DW'($urandom), 1'b1, 0);
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
